alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority to port 0.
REQ-002 SHALL have port: clk_i  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: req0_valid_i, req1_valid_i  input  1  each  requester has an operation pending.
REQ-005 SHALL have ports: req0_ready_o, req1_ready_o  output  1  each  request accepted this cycle.
REQ-006 SHALL have ports: req0_func_i, req1_func_i  input  3  each  ALU opcode (000 ADI ... 111 LSR).
REQ-007 SHALL have ports: req0_a_i, req1_a_i, req0_b_i, req1_b_i  input  8  each  operands A and B.
REQ-008 SHALL have port: rsp_valid_o  output  1  result available.
REQ-009 SHALL have port: rsp_ready_i  input  1  consumer takes result.
REQ-010 SHALL have ports: rsp_data_o  output  8; rsp_fz_o, rsp_fc_o  output  1 each; rsp_id_o  output  1 (0/1 = originating port).
REQ-011 SHALL have ports: alu_a_imm_o, alu_a_mem_o, alu_b_o  output  8 each; alu_func_o  output  3  drive the shared ALU.
REQ-012 SHALL have ports: alu_result_i  input  8; alu_fz_i, alu_fc_i  input  1 each  combinational ALU return.
REQ-013 SHALL have ports: flags_o  output  2  {fz,fc} of last completed op; busy_o  output  1  state != IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP; one op in flight at a time.
REQ-015 IDLE: if no valid request, stay IDLE; else grant one port, assert only its ready combinationally, latch its func/A/B plus id at the edge, go EXEC.
REQ-016 Arbitration with both valid: RR_EN=1 grants the port indicated by priority pointer; RR_EN=0 always grants port 0.
REQ-017 Priority pointer SHALL flip to the non-granted port on every grant (RR_EN=1 only); single requester is granted regardless of pointer.
REQ-018 ready outputs SHALL be 0 in EXEC and RESP; a requester holding valid while not granted keeps its request with no loss.
REQ-019 alu_func_o, alu_b_o and both alu_a_imm_o and alu_a_mem_o (same latched A) SHALL be driven from latched registers in all states.
REQ-020 EXEC: at the edge, capture alu_result_i, alu_fz_i, alu_fc_i into response registers and flags_o, go RESP; EXEC lasts exactly one cycle.
REQ-021 RESP: rsp_valid_o=1 with rsp_data_o/rsp_fz_o/rsp_fc_o/rsp_id_o stable until the edge where rsp_ready_i=1, then go IDLE.
REQ-022 Latency: request accepted at edge T -> rsp_valid_o high after edge T+1; with rsp_ready_i held 1, next grant possible in cycle after edge T+2 (one op per 3 cycles).
REQ-023 rsp_valid_o SHALL be 0 in IDLE and EXEC; request inputs SHALL be ignored outside IDLE.
REQ-024 flags_o SHALL update only in EXEC; unchanged while idle or stalled in RESP.
REQ-025 No arithmetic in this block; result width 8, carry from ALU passed unmodified.

Reset
REQ-026 rst_ni low SHALL immediately force state IDLE, priority pointer to port 0, all latched operands/func/id to 0, response registers and flags_o to 0.
REQ-027 During reset all ready, rsp_valid_o, busy_o SHALL be 0; reset mid-EXEC or mid-RESP discards the op with no response.
REQ-028 First grant after reset deassertion SHALL be no earlier than the first rising edge with rst_ni high.

Verification
REQ-029 Port0 ADD A=8'hF0 B=8'h20, rsp_ready_i=1 -> req0_ready_o pulse, after 2 edges rsp_data_o=8'h10, rsp_fc_o=1, rsp_fz_o=0, rsp_id_o=0.
REQ-030 Both ports valid continuously, RR_EN=1, after reset -> grants alternate 0,1,0,1; rsp_id_o sequence 0,1,0,1.
REQ-031 Same with RR_EN=0 -> all grants to port 0; req1_ready_o never asserts while req0_valid_i=1.
REQ-032 Port1 SUB A=5 B=5, rsp_ready_i=0 for 4 cycles -> rsp_valid_o held, data=0, fz=1 stable; new requests not accepted until release.
REQ-033 Assert rst_ni low in RESP -> rsp_valid_o, busy_o, flags_o go 0 without clock edge; after release, pending port1 request granted first cycle (no stale response).
REQ-034 Port0 LSR B=8'h81 then port0 ADI A=0 B=0 -> flags_o {0,0} then {1,0}; alu_a_imm_o equals alu_a_mem_o throughout.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-port arbiter that serialises operations onto one shared external ALU.
// One op in flight at a time; result held in a response register until consumed.
module alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req0_valid_i,
  input  logic       req1_valid_i,
  output logic       req0_ready_o,
  output logic       req1_ready_o,
  input  logic [2:0] req0_func_i,
  input  logic [2:0] req1_func_i,
  input  logic [7:0] req0_a_i,
  input  logic [7:0] req1_a_i,
  input  logic [7:0] req0_b_i,
  input  logic [7:0] req1_b_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_data_o,
  output logic       rsp_fz_o,
  output logic       rsp_fc_o,
  output logic       rsp_id_o,
  output logic [7:0] alu_a_imm_o,
  output logic [7:0] alu_a_mem_o,
  output logic [7:0] alu_b_o,
  output logic [2:0] alu_func_o,
  input  logic [7:0] alu_result_i,
  input  logic       alu_fz_i,
  input  logic       alu_fc_i,
  output logic [1:0] flags_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q;
  logic       ptr_q;
  logic [2:0] func_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic       id_q;
  logic [7:0] rsp_data_q;
  logic       rsp_fz_q;
  logic       rsp_fc_q;
  logic [1:0] flags_q;

  logic       grant_d;
  logic       grant_id_d;
  logic [2:0] func_d;
  logic [7:0] a_d;
  logic [7:0] b_d;

  // A lone requester wins regardless of the pointer; the pointer only breaks ties.
  always_comb begin
    grant_id_d = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grant_id_d = RR_EN ? ptr_q : 1'b0;
    end else begin
      grant_id_d = req1_valid_i;
    end
    // rst_ni gates the grant so no ready leaks out while reset is held.
    grant_d = rst_ni && (state_q == IDLE) && (req0_valid_i || req1_valid_i);
    func_d  = grant_id_d ? req1_func_i : req0_func_i;
    a_d     = grant_id_d ? req1_a_i    : req0_a_i;
    b_d     = grant_id_d ? req1_b_i    : req0_b_i;
  end

  assign req0_ready_o = grant_d && !grant_id_d;
  assign req1_ready_o = grant_d &&  grant_id_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      func_q     <= 3'd0;
      a_q        <= 8'd0;
      b_q        <= 8'd0;
      id_q       <= 1'b0;
      rsp_data_q <= 8'd0;
      rsp_fz_q   <= 1'b0;
      rsp_fc_q   <= 1'b0;
      flags_q    <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            func_q  <= func_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= grant_id_d;
            if (RR_EN) begin
              ptr_q <= ~grant_id_d;
            end
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q <= alu_result_i;
          rsp_fz_q   <= alu_fz_i;
          rsp_fc_q   <= alu_fc_i;
          flags_q    <= {alu_fz_i, alu_fc_i};
          state_q    <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid_o = (state_q == RESP);
  assign busy_o      = (state_q != IDLE);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_fz_o    = rsp_fz_q;
  assign rsp_fc_o    = rsp_fc_q;
  assign rsp_id_o    = id_q;
  assign flags_o     = flags_q;

  // Both A ports carry the same latched operand; the ALU picks its source by opcode.
  assign alu_a_imm_o = a_q;
  assign alu_a_mem_o = a_q;
  assign alu_b_o     = b_q;
  assign alu_func_o  = func_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (round-robin and fixed priority) share
// stimulus; each drives its own behavioural ALU and is checked against a model.
module tb_alu_arbiter;

  logic clk;
  logic rst_n;
  logic v0, v1, rr;
  logic [2:0] f0, f1;
  logic [7:0] a0, a1, b0, b1;

  logic [1:0] r0, r1, rv, rfz, rfc, rid, fz_i, fc_i, busy;
  logic [7:0] rdata [2];
  logic [7:0] aimm  [2];
  logic [7:0] amem  [2];
  logic [7:0] ab    [2];
  logic [7:0] ares  [2];
  logic [2:0] afunc [2];
  logic [1:0] flags [2];

  int n_checks = 0;
  int n_err    = 0;

  // Environment ALU: 0 ADI,1 ADD,2 SUB(borrow),3 AND,4 OR,5 XOR,6 LSL,7 LSR.
  function automatic logic [9:0] alu_ref(input logic [2:0] f, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [8:0] w;
    w = 9'd0;
    case (f)
      3'd0, 3'd1: w = {1'b0, a} + {1'b0, b};
      3'd2:       w = {1'b0, a} - {1'b0, b};
      3'd3:       w = {1'b0, a & b};
      3'd4:       w = {1'b0, a | b};
      3'd5:       w = {1'b0, a ^ b};
      3'd6:       w = {a, 1'b0};
      default:    w = {a[0], 1'b0, a[7:1]};
    endcase
    return {w[7:0], (w[7:0] == 8'd0), w[8]};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    alu_arbiter #(.RR_EN(gi == 0)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req0_valid_i(v0), .req1_valid_i(v1),
      .req0_ready_o(r0[gi]), .req1_ready_o(r1[gi]),
      .req0_func_i(f0), .req1_func_i(f1),
      .req0_a_i(a0), .req1_a_i(a1), .req0_b_i(b0), .req1_b_i(b1),
      .rsp_valid_o(rv[gi]), .rsp_ready_i(rr),
      .rsp_data_o(rdata[gi]), .rsp_fz_o(rfz[gi]), .rsp_fc_o(rfc[gi]), .rsp_id_o(rid[gi]),
      .alu_a_imm_o(aimm[gi]), .alu_a_mem_o(amem[gi]), .alu_b_o(ab[gi]), .alu_func_o(afunc[gi]),
      .alu_result_i(ares[gi]), .alu_fz_i(fz_i[gi]), .alu_fc_i(fc_i[gi]),
      .flags_o(flags[gi]), .busy_o(busy[gi])
    );
    assign {ares[gi], fz_i[gi], fc_i[gi]} =
      alu_ref(afunc[gi], (afunc[gi] == 3'd0) ? aimm[gi] : amem[gi], ab[gi]);
  end

  // Model: 0 = waiting for a request, 1 = op executing, 2 = response held.
  int         m_st    [2];
  bit         m_ptr   [2];
  logic [2:0] m_func  [2];
  logic [7:0] m_a     [2];
  logic [7:0] m_b     [2];
  bit         m_id    [2];
  logic [7:0] m_data  [2];
  bit         m_fz    [2];
  bit         m_fc    [2];
  logic [1:0] m_flags [2];

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", name, k, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_ptr[k] = 1'b0; m_func[k] = 3'd0; m_a[k] = 8'd0; m_b[k] = 8'd0;
      m_id[k] = 1'b0; m_data[k] = 8'd0; m_fz[k] = 1'b0; m_fc[k] = 1'b0; m_flags[k] = 2'b00;
    end
  endtask

  function automatic int exp_grant(input int k);
    if (!rst_n || m_st[k] != 0) return -1;
    if (v0 && v1) return (k == 0) ? int'(m_ptr[k]) : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic check_all();
    int g;
    for (int k = 0; k < 2; k++) begin
      g = exp_grant(k);
      chk("req0_ready", k, r0[k], g == 0);
      chk("req1_ready", k, r1[k], g == 1);
      chk("rsp_valid", k, rv[k], m_st[k] == 2);
      chk("busy", k, busy[k], m_st[k] != 0);
      chk("flags", k, flags[k], m_flags[k]);
      chk("rsp_data", k, rdata[k], m_data[k]);
      chk("rsp_fz", k, rfz[k], m_fz[k]);
      chk("rsp_fc", k, rfc[k], m_fc[k]);
      chk("rsp_id", k, rid[k], m_id[k]);
      chk("alu_a_imm", k, aimm[k], m_a[k]);
      chk("alu_a_mem", k, amem[k], m_a[k]);
      chk("alu_b", k, ab[k], m_b[k]);
      chk("alu_func", k, afunc[k], m_func[k]);
    end
  endtask

  task automatic model_next();
    int g;
    logic [9:0] r;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      case (m_st[k])
        0: begin
          g = exp_grant(k);
          if (g >= 0) begin
            m_func[k] = (g == 1) ? f1 : f0;
            m_a[k]    = (g == 1) ? a1 : a0;
            m_b[k]    = (g == 1) ? b1 : b0;
            m_id[k]   = (g == 1);
            if (k == 0) m_ptr[k] = (g == 0);
            m_st[k]   = 1;
          end
        end
        1: begin
          r = alu_ref(m_func[k], m_a[k], m_b[k]);
          m_data[k] = r[9:2]; m_fz[k] = r[1]; m_fc[k] = r[0];
          m_flags[k] = r[1:0];
          m_st[k] = 2;
        end
        default: if (rr) m_st[k] = 0;
      endcase
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    #2;
    if (!rst_n) model_reset();
    check_all();
    model_next();
    @(negedge clk);
  endtask

  int gseq [2][$];
  int iseq [2][$];
  int r1_hits;

  initial begin
    rst_n = 1'b0; v0 = 0; v1 = 0; rr = 0;
    f0 = 0; f1 = 0; a0 = 0; a1 = 0; b0 = 0; b1 = 0;
    model_reset();
    @(negedge clk);
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      chk("reset_rsp_valid", k, rv[k], 1'b0);
      chk("reset_busy", k, busy[k], 1'b0);
      chk("reset_flags", k, flags[k], 2'b00);
    end
    rst_n = 1'b1;

    // Port0 ADD F0+20 -> 10 with carry, response after two edges.
    v0 = 1; f0 = 3'd1; a0 = 8'hF0; b0 = 8'h20; rr = 1;
    #1;
    for (int k = 0; k < 2; k++) chk("add_ready0", k, r0[k], 1'b1);
    tick();
    v0 = 0;
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("add_valid", k, rv[k], 1'b1);
      chk("add_data", k, rdata[k], 8'h10);
      chk("add_fc", k, rfc[k], 1'b1);
      chk("add_fz", k, rfz[k], 1'b0);
      chk("add_id", k, rid[k], 1'b0);
    end
    tick();
    tick();

    // Both ports continuously valid from reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; v0 = 1; v1 = 1; rr = 1; r1_hits = 0;
    for (int i = 0; i < 12; i++) begin
      a0 = 8'($urandom); a1 = 8'($urandom); b0 = 8'($urandom); b1 = 8'($urandom);
      f0 = 3'($urandom); f1 = 3'($urandom);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (r0[k]) gseq[k].push_back(0);
        if (r1[k]) gseq[k].push_back(1);
        if (rv[k]) iseq[k].push_back(int'(rid[k]));
      end
      if (r1[1]) r1_hits++;
      tick();
    end
    chk("rr_grant_count", 0, gseq[0].size(), 4);
    chk("fp_grant_count", 1, gseq[1].size(), 4);
    chk("rr_id_count", 0, iseq[0].size(), 4);
    for (int i = 0; i < 4 && i < gseq[0].size() && i < gseq[1].size(); i++) begin
      chk("rr_grant_seq", 0, gseq[0][i], i % 2);
      chk("fp_grant_seq", 1, gseq[1][i], 0);
    end
    for (int i = 0; i < 4 && i < iseq[0].size() && i < iseq[1].size(); i++) begin
      chk("rr_id_seq", 0, iseq[0][i], i % 2);
      chk("fp_id_seq", 1, iseq[1][i], 0);
    end
    chk("fp_req1_ready_hits", 1, r1_hits, 0);

    // Port1 SUB 5-5 stalled four cycles in response.
    v0 = 0; v1 = 1; f1 = 3'd2; a1 = 8'd5; b1 = 8'd5; rr = 0;
    tick();
    v0 = 1; a0 = 8'h33; a1 = 8'h44;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        chk("stall_valid", k, rv[k], 1'b1);
        chk("stall_data", k, rdata[k], 8'h00);
        chk("stall_fz", k, rfz[k], 1'b1);
        chk("stall_ready0", k, r0[k], 1'b0);
        chk("stall_ready1", k, r1[k], 1'b0);
      end
      tick();
    end
    rr = 1; v0 = 0; v1 = 0;
    tick();

    // Reset asserted in response; pending port1 request wins right after release.
    v1 = 1; f1 = 3'd3; a1 = 8'h0F; b1 = 8'hF0; rr = 0;
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("arst_rsp_valid", k, rv[k], 1'b0);
      chk("arst_busy", k, busy[k], 1'b0);
      chk("arst_flags", k, flags[k], 2'b00);
    end
    tick();
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) chk("post_rst_ready1", k, r1[k], 1'b1);
    tick();
    v1 = 0; rr = 1;
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("post_rst_id", k, rid[k], 1'b1);
      chk("post_rst_flags", k, flags[k], 2'b10);
    end
    tick();

    // LSR then ADI 0+0: flags {0,0} then {1,0}.
    v0 = 1; f0 = 3'd7; a0 = 8'h40; b0 = 8'h81;
    tick();
    v0 = 0;
    tick();
    for (int k = 0; k < 2; k++) chk("lsr_flags", k, flags[k], 2'b00);
    tick();
    v0 = 1; f0 = 3'd0; a0 = 8'h00; b0 = 8'h00;
    tick();
    v0 = 0;
    tick();
    for (int k = 0; k < 2; k++) chk("adi_flags", k, flags[k], 2'b10);
    tick();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      f0 = 3'($urandom); f1 = 3'($urandom);
      a0 = 8'($urandom); a1 = 8'($urandom); b0 = 8'($urandom); b1 = 8'($urandom);
      rr = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 149) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
